// File: rtl/cu_dispatch.sv
// cu_dispatch: issue stage in front of the CU.
// Requests are queued in a small circular FIFO. Each request is presented to
// the CU and held stable for that operation's fixed latency. The stage also
// manages the CU power mode: LP after IDLE_LP empty idle cycles, and a
// one-cycle WAKE at NORMAL before issuing out of LP.
// Optional build macro CU_DISPATCH_STATS_EN adds saturating issue and
// LP-cycle counters (stat_issued, stat_lp_cycles).

package cu_dispatch_pkg;
   typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, CMP = 2'd3} operation_t;
   typedef enum logic {LP = 1'b0, NORMAL = 1'b1} powermode_t;
endpackage

module cu_dispatch
   import cu_dispatch_pkg::*;
#(
   parameter int W       = 16,
   parameter int DEPTH   = 4,
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 4,
   parameter int IDLE_LP = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_op1,
   input  logic [W-1:0]             in_op2,
   input  operation_t               in_op,
   output logic [W-1:0]             cu_op1,
   output logic [W-1:0]             cu_op2,
   output operation_t               cu_op,
   output powermode_t               cu_pmode,
   output logic                     cu_issue,
   output logic                     res_valid,
   output logic [$clog2(DEPTH):0]   count
`ifdef CU_DISPATCH_STATS_EN
   ,
   output logic [15:0]              stat_issued,
   output logic [15:0]              stat_lp_cycles
`endif
);

   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;
   localparam int MAXLAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
   localparam int HW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;
   localparam int IW     = $clog2(IDLE_LP + 1);

   typedef enum logic [2:0] {SLEEP, WAKE, ISSUE, HOLD, IDLE} state_t;

   typedef struct packed {
      logic [W-1:0] op1;
      logic [W-1:0] op2;
      operation_t   op;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop;
   entry_t          head;

   state_t          state_q;
   powermode_t      pmode_q;
   logic [W-1:0]    op1_q, op2_q;
   operation_t      op_q;
   logic            issue_q, rv_q;
   logic [HW-1:0]   hold_q;
   logic [IW-1:0]   idle_q;

   // Hold counter preload: remaining cycles after the issue cycle.
   function automatic logic [HW-1:0] hold_init(input operation_t op);
      if (op == MUL) return HW'(MUL_LAT - 1);
      return HW'(ADD_LAT - 1);
   endfunction

   // Ready looks only at the registered occupancy, so a same-cycle pop
   // never makes room for a push into a full FIFO.
   assign in_ready = !rst && (count_q < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign head     = mem_q[rd_ptr_q];

   // Pop whenever a new op is about to be issued: after WAKE, from IDLE,
   // or on the last hold cycle of the current op (back-to-back).
   always_comb begin
      pop = 1'b0;
      case (state_q)
         WAKE:        pop = (count_q != '0);
         IDLE:        pop = (count_q != '0);
         ISSUE, HOLD: pop = rv_q && (count_q != '0);
         default:     pop = 1'b0;
      endcase
   end

   // Occupancy next-state; simultaneous push and pop cancel out.
   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   // FIFO control: pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // FIFO storage: data only, flushed logically by the pointer reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{op1: in_op1, op2: in_op2, op: in_op};
   end

   // Issue/power FSM with registered CU-facing outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLEEP;
         pmode_q <= LP;
         op1_q   <= '0;
         op2_q   <= '0;
         op_q    <= ADD;
         issue_q <= 1'b0;
         rv_q    <= 1'b0;
         hold_q  <= '0;
         idle_q  <= '0;
      end else begin
         issue_q <= 1'b0;
         rv_q    <= 1'b0;
         if (pop) begin
            state_q <= ISSUE;
            pmode_q <= NORMAL;
            op1_q   <= head.op1;
            op2_q   <= head.op2;
            op_q    <= head.op;
            issue_q <= 1'b1;
            hold_q  <= hold_init(head.op);
            rv_q    <= (hold_init(head.op) == '0);
            idle_q  <= '0;
         end else begin
            case (state_q)
               SLEEP: begin
                  if (count_q != '0) begin
                     state_q <= WAKE;
                     pmode_q <= NORMAL;
                  end
               end
               WAKE: state_q <= IDLE;
               ISSUE, HOLD: begin
                  if (rv_q) begin
                     state_q <= IDLE;
                     idle_q  <= '0;
                  end else begin
                     state_q <= HOLD;
                     hold_q  <= hold_q - 1'b1;
                     rv_q    <= (hold_q == HW'(1));
                  end
               end
               IDLE: begin
                  if (idle_q == IW'(IDLE_LP - 1)) begin
                     state_q <= SLEEP;
                     pmode_q <= LP;
                     idle_q  <= '0;
                  end else begin
                     idle_q <= idle_q + 1'b1;
                  end
               end
               default: state_q <= SLEEP;
            endcase
         end
      end
   end

   assign cu_op1    = op1_q;
   assign cu_op2    = op2_q;
   assign cu_op     = op_q;
   assign cu_pmode  = pmode_q;
   assign cu_issue  = issue_q;
   assign res_valid = rv_q;
   assign count     = count_q;

`ifdef CU_DISPATCH_STATS_EN
   logic [15:0] stat_issued_q, stat_lp_q;

   // Saturating activity counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued_q <= '0;
         stat_lp_q     <= '0;
      end else begin
         if (issue_q && (stat_issued_q != 16'hFFFF)) stat_issued_q <= stat_issued_q + 16'd1;
         if ((pmode_q == LP) && (stat_lp_q != 16'hFFFF)) stat_lp_q <= stat_lp_q + 16'd1;
      end
   end

   assign stat_issued    = stat_issued_q;
   assign stat_lp_cycles = stat_lp_q;
`endif

endmodule
